// File: rtl/rng_debias_packer.sv
// Health-tests a raw ring-oscillator bit stream, removes bias with a von Neumann
// pair extractor and packs the surviving bits MSB-first into a one-deep output register.
module rng_debias_packer #(
  parameter int WORD_WIDTH     = 32,
  parameter int REP_LIMIT      = 32,
  parameter int DROP_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      bit_in,
  input  logic                      bit_valid,
  output logic [WORD_WIDTH-1:0]     word_out,
  output logic                      word_valid,
  input  logic                      word_ready,
  output logic                      health_fail,
  input  logic                      clear_fail,
  output logic [DROP_CNT_WIDTH-1:0] drop_count
);

  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam int CW = $clog2(WORD_WIDTH);

  localparam logic [0:0] ST_IDLE       = 1'b0;
  localparam logic [0:0] ST_HAVE_FIRST = 1'b1;

  // Output handshake: a word transfers on any clk edge where word_valid and
  // word_ready are both 1; word_out is held stable while word_valid=1 and word_ready=0.

  logic [0:0]                pair_state_q, pair_state_d;
  logic                      first_q, first_d;
  logic [WORD_WIDTH-1:0]     acc_q, acc_d;
  logic [CW-1:0]             bit_cnt_q, bit_cnt_d;
  logic [RW-1:0]             rep_cnt_q, rep_cnt_d;
  logic                      last_bit_q, last_bit_d;
  logic                      health_fail_q, health_fail_d;
  logic [WORD_WIDTH-1:0]     word_out_q, word_out_d;
  logic                      word_valid_q, word_valid_d;
  logic [DROP_CNT_WIDTH-1:0] drop_count_q, drop_count_d;

  logic [RW-1:0]             rep_next;
  logic                      trip;
  logic                      db_valid;
  logic                      db_bit;
  logic                      word_done;
  logic                      out_free;
  logic [WORD_WIDTH-1:0]     new_word;

  always_comb begin
    pair_state_d  = pair_state_q;
    first_d       = first_q;
    acc_d         = acc_q;
    bit_cnt_d     = bit_cnt_q;
    rep_cnt_d     = rep_cnt_q;
    last_bit_d    = last_bit_q;
    health_fail_d = health_fail_q;
    word_out_d    = word_out_q;
    word_valid_d  = word_valid_q;
    drop_count_d  = drop_count_q;
    db_valid      = 1'b0;
    db_bit        = first_q;

    // rep_cnt of zero marks "no previous bit" after reset or clear_fail.
    rep_next = rep_cnt_q;
    if (rep_cnt_q == '0 || bit_in != last_bit_q) begin
      rep_next = RW'(1);
    end else if (rep_cnt_q != RW'(REP_LIMIT)) begin
      rep_next = rep_cnt_q + 1'b1;
    end
    trip = bit_valid && !health_fail_q && (rep_next == RW'(REP_LIMIT));

    if (clear_fail) begin
      health_fail_d = 1'b0;
      rep_cnt_d     = '0;
      pair_state_d  = ST_IDLE;
      acc_d         = '0;
      bit_cnt_d     = '0;
    end else if (bit_valid) begin
      rep_cnt_d  = rep_next;
      last_bit_d = bit_in;
      if (trip) begin
        health_fail_d = 1'b1;
        pair_state_d  = ST_IDLE;
      end else if (!health_fail_q) begin
        case (pair_state_q)
          ST_IDLE: begin
            first_d      = bit_in;
            pair_state_d = ST_HAVE_FIRST;
          end
          default: begin
            db_valid     = (bit_in != first_q);
            pair_state_d = ST_IDLE;
          end
        endcase
      end
    end

    new_word  = {acc_q[WORD_WIDTH-2:0], db_bit};
    word_done = db_valid && (bit_cnt_q == CW'(WORD_WIDTH - 1));
    if (db_valid) begin
      acc_d     = new_word;
      bit_cnt_d = word_done ? '0 : bit_cnt_q + 1'b1;
    end

    out_free = !word_valid_q || word_ready;
    if (word_done && out_free) begin
      word_out_d   = new_word;
      word_valid_d = 1'b1;
    end else begin
      if (word_done && drop_count_q != '1) begin
        drop_count_d = drop_count_q + 1'b1;
      end
      if (word_valid_q && word_ready) begin
        word_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pair_state_q  <= ST_IDLE;
      first_q       <= 1'b0;
      acc_q         <= '0;
      bit_cnt_q     <= '0;
      rep_cnt_q     <= '0;
      last_bit_q    <= 1'b0;
      health_fail_q <= 1'b0;
      word_out_q    <= '0;
      word_valid_q  <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      pair_state_q  <= pair_state_d;
      first_q       <= first_d;
      acc_q         <= acc_d;
      bit_cnt_q     <= bit_cnt_d;
      rep_cnt_q     <= rep_cnt_d;
      last_bit_q    <= last_bit_d;
      health_fail_q <= health_fail_d;
      word_out_q    <= word_out_d;
      word_valid_q  <= word_valid_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign word_out    = word_out_q;
  assign word_valid  = word_valid_q;
  assign health_fail = health_fail_q;
  assign drop_count  = drop_count_q;

endmodule
